// File: rtl/td4_pkg.sv
// td4_pkg: shared definitions for the TD4-style load sequencer.
//   Opcode constants, ALU source (SEL) encodings, LOAD_N chip-select bit
//   indices and the sequencer state encoding.
//   Macro TD4_HALT_EN adds the HALT state (and the halt opcode semantics).
package td4_pkg;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_HALT     = 4'b1000;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int unsigned LD_A   = 0;
  localparam int unsigned LD_B   = 1;
  localparam int unsigned LD_OUT = 2;
  localparam int unsigned LD_PC  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1
`ifdef TD4_HALT_EN
    ,
    ST_HALT = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/load_sequencer_decoder.sv
// opcode_decoder: combinational decode of a TD4 opcode.
//   i_opcode   - 4-bit opcode
//   i_c_flag   - latched carry flag (JNC condition)
//   o_sel      - ALU source select
//   o_im_en    - pass the immediate field to the ALU
//   o_load_n   - active-low register chip selects [0]A [1]B [2]OUT [3]PC
//   o_pc_inc_n - active-low PC increment strobe
//   o_halt     - halt opcode (only with TD4_HALT_EN)
// Undefined opcodes decode as NOP (no loads, PC increments).
module opcode_decoder
  import td4_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_c_flag,
  output logic [1:0] o_sel,
  output logic       o_im_en,
  output logic [3:0] o_load_n,
`ifdef TD4_HALT_EN
  output logic       o_halt,
`endif
  output logic       o_pc_inc_n
);

  logic w_halt;

  always_comb begin
    o_sel    = SEL_ZERO;
    o_im_en  = 1'b0;
    o_load_n = '1;
    w_halt   = 1'b0;
    case (i_opcode)
      OP_ADD_A_IM: begin o_sel = SEL_A;    o_im_en = 1'b1; o_load_n[LD_A]   = 1'b0; end
      OP_ADD_B_IM: begin o_sel = SEL_B;    o_im_en = 1'b1; o_load_n[LD_B]   = 1'b0; end
      OP_MOV_A_IM: begin o_sel = SEL_ZERO; o_im_en = 1'b1; o_load_n[LD_A]   = 1'b0; end
      OP_MOV_B_IM: begin o_sel = SEL_ZERO; o_im_en = 1'b1; o_load_n[LD_B]   = 1'b0; end
      OP_MOV_A_B:  begin o_sel = SEL_B;                    o_load_n[LD_A]   = 1'b0; end
      OP_MOV_B_A:  begin o_sel = SEL_A;                    o_load_n[LD_B]   = 1'b0; end
      OP_IN_A:     begin o_sel = SEL_IN;                   o_load_n[LD_A]   = 1'b0; end
      OP_IN_B:     begin o_sel = SEL_IN;                   o_load_n[LD_B]   = 1'b0; end
      OP_OUT_IM:   begin o_sel = SEL_ZERO; o_im_en = 1'b1; o_load_n[LD_OUT] = 1'b0; end
      OP_OUT_B:    begin o_sel = SEL_B;                    o_load_n[LD_OUT] = 1'b0; end
      OP_JMP:      begin o_sel = SEL_ZERO; o_im_en = 1'b1; o_load_n[LD_PC]  = 1'b0; end
      // Not-taken JNC keeps SEL/IM but suppresses the PC load, falling back to increment.
      OP_JNC:      begin o_sel = SEL_ZERO; o_im_en = 1'b1; o_load_n[LD_PC]  = i_c_flag; end
`ifdef TD4_HALT_EN
      OP_HALT:     w_halt = 1'b1;
`endif
      default: ;
    endcase
    // PC either loads or increments, never both; a halt does neither.
    o_pc_inc_n = w_halt | ~o_load_n[LD_PC];
  end

`ifdef TD4_HALT_EN
  assign o_halt = w_halt;
`endif

endmodule

// File: rtl/load_sequencer.sv
// load_sequencer: two-cycle instruction sequencer for a TD4-style CPU.
//   Accepts INSTR on VALID in IDLE (READY=1), then spends one EXEC cycle
//   driving the ALU select, immediate and register strobes decoded from the
//   latched instruction, latching CARRY_IN into C_FLAG at the end of EXEC.
//   Ports: CLK, CLR (async active-low), INSTR[bitWidth+3:0], VALID, READY,
//          CARRY_IN, SEL[1:0], IM[bitWidth-1:0], LOAD_N[3:0], PC_INC_N,
//          C_FLAG, HALTED.
//   Macro TD4_HALT_EN: opcode 1000 halts the sequencer until CLR.
module load_sequencer
  import td4_pkg::*;
#(
  parameter int unsigned bitWidth = 4
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [bitWidth+3:0] INSTR,
  input  logic                VALID,
  output logic                READY,
  input  logic                CARRY_IN,
  output logic [1:0]          SEL,
  output logic [bitWidth-1:0] IM,
  output logic [3:0]          LOAD_N,
  output logic                PC_INC_N,
  output logic                C_FLAG,
  output logic                HALTED
);

  state_t              r_state;
  state_t              w_next_state;
  logic [bitWidth+3:0] r_instr;
  logic                r_c_flag;

  logic [1:0]          w_sel;
  logic                w_im_en;
  logic [3:0]          w_load_n;
  logic                w_pc_inc_n;
`ifdef TD4_HALT_EN
  logic                w_halt;
`endif

  opcode_decoder u_decoder (
    .i_opcode   (r_instr[bitWidth+3:bitWidth]),
    .i_c_flag   (r_c_flag),
    .o_sel      (w_sel),
    .o_im_en    (w_im_en),
    .o_load_n   (w_load_n),
`ifdef TD4_HALT_EN
    .o_halt     (w_halt),
`endif
    .o_pc_inc_n (w_pc_inc_n)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state  <= ST_IDLE;
      r_instr  <= '0;
      r_c_flag <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && VALID) r_instr <= INSTR;
      if (r_state == ST_EXEC) r_c_flag <= CARRY_IN;
    end
  end

  // Outputs are pure functions of state so an asynchronous CLR drops every strobe at once.
  always_comb begin
    w_next_state = r_state;
    READY        = 1'b0;
    SEL          = SEL_ZERO;
    IM           = '0;
    LOAD_N       = '1;
    PC_INC_N     = 1'b1;
    HALTED       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        READY = 1'b1;
        if (VALID) w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        SEL          = w_sel;
        IM           = w_im_en ? r_instr[bitWidth-1:0] : '0;
        LOAD_N       = w_load_n;
        PC_INC_N     = w_pc_inc_n;
        w_next_state = ST_IDLE;
`ifdef TD4_HALT_EN
        if (w_halt) w_next_state = ST_HALT;
`endif
      end
`ifdef TD4_HALT_EN
      ST_HALT: HALTED = 1'b1;
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign C_FLAG = r_c_flag;

endmodule

// File: tb/tb_load_sequencer.sv
module tb_load_sequencer;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] INSTR = '0;
  logic       VALID = 1'b0;
  logic       READY;
  logic       CARRY_IN = 1'b0;
  logic [1:0] SEL;
  logic [3:0] IM;
  logic [3:0] LOAD_N;
  logic       PC_INC_N;
  logic       C_FLAG;
  logic       HALTED;

  int checks = 0;
  int errors = 0;

  load_sequencer #(.bitWidth(4)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .INSTR    (INSTR),
    .VALID    (VALID),
    .READY    (READY),
    .CARRY_IN (CARRY_IN),
    .SEL      (SEL),
    .IM       (IM),
    .LOAD_N   (LOAD_N),
    .PC_INC_N (PC_INC_N),
    .C_FLAG   (C_FLAG),
    .HALTED   (HALTED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] instr;
    logic       cpre;
    logic [1:0] sel;
    logic [3:0] im;
    logic [3:0] load_n;
    logic       pc_inc_n;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] im;
    logic [3:0] load_n;
    logic       pc_inc_n;
    logic       halt;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && READY !== 1'b1; i++) tick();
    if (READY !== 1'b1) chk("ready_timeout", {31'd0, READY}, 32'd1);
  endtask

  // Leaves the DUT in its EXEC cycle.
  task automatic issue(input logic [7:0] ins);
    wait_ready();
    INSTR = ins;
    VALID = 1'b1;
    tick();
    VALID = 1'b0;
  endtask

  // Completes the EXEC cycle with the given ALU carry.
  task automatic retire(input logic carry);
    CARRY_IN = carry;
    tick();
  endtask

  // Reference semantics: each opcode names a destination register (or none),
  // an ALU source, and whether the immediate is used.
  function automatic exp_t model(input logic [7:0] ins, input logic cf);
    exp_t e;
    int   dest;      // 0 A, 1 B, 2 OUT, 3 PC, -1 none
    int   src;       // 0 A, 1 B, 2 IN, 3 zero
    bit   use_im;
    bit   halt_op;
    dest = -1; src = 3; use_im = 0; halt_op = 0;
    unique case (ins[7:4])
      4'h0: begin dest = 0; src = 0; use_im = 1; end
      4'h5: begin dest = 1; src = 1; use_im = 1; end
      4'h3: begin dest = 0; src = 3; use_im = 1; end
      4'h7: begin dest = 1; src = 3; use_im = 1; end
      4'h1: begin dest = 0; src = 1; end
      4'h4: begin dest = 1; src = 0; end
      4'h2: begin dest = 0; src = 2; end
      4'h6: begin dest = 1; src = 2; end
      4'hB: begin dest = 2; src = 3; use_im = 1; end
      4'h9: begin dest = 2; src = 1; end
      4'hF: begin dest = 3; src = 3; use_im = 1; end
      4'hE: begin dest = (cf == 1'b0) ? 3 : -1; src = 3; use_im = 1; end
`ifdef TD4_HALT_EN
      4'h8: halt_op = 1;
`endif
      default: ;
    endcase
    e.sel      = 2'(src);
    e.im       = use_im ? ins[3:0] : 4'h0;
    e.load_n   = (dest < 0) ? 4'hF : ~(4'b0001 << dest);
    e.pc_inc_n = halt_op ? 1'b1 : (dest == 3);
    e.halt     = halt_op;
    return e;
  endfunction

  vec_t vecs[$];
  exp_t e;
  logic cf_model;
  int   exec_count;
  logic c;

  initial begin
    vecs = '{
      '{8'h03, 1'b0, 2'b00, 4'h3, 4'b1110, 1'b0},
      '{8'h5A, 1'b0, 2'b01, 4'hA, 4'b1101, 1'b0},
      '{8'h37, 1'b1, 2'b11, 4'h7, 4'b1110, 1'b0},
      '{8'h7C, 1'b0, 2'b11, 4'hC, 4'b1101, 1'b0},
      '{8'h19, 1'b0, 2'b01, 4'h0, 4'b1110, 1'b0},
      '{8'h4F, 1'b1, 2'b00, 4'h0, 4'b1101, 1'b0},
      '{8'h2F, 1'b0, 2'b10, 4'h0, 4'b1110, 1'b0},
      '{8'h6F, 1'b0, 2'b10, 4'h0, 4'b1101, 1'b0},
      '{8'hB9, 1'b0, 2'b11, 4'h9, 4'b1011, 1'b0},
      '{8'h9F, 1'b1, 2'b01, 4'h0, 4'b1011, 1'b0},
      '{8'hF4, 1'b1, 2'b11, 4'h4, 4'b0111, 1'b1},
      '{8'hE5, 1'b0, 2'b11, 4'h5, 4'b0111, 1'b1},
      '{8'hE5, 1'b1, 2'b11, 4'h5, 4'b1111, 1'b0},
      '{8'hA0, 1'b0, 2'b11, 4'h0, 4'b1111, 1'b0},
      '{8'hC7, 1'b1, 2'b11, 4'h0, 4'b1111, 1'b0},
      '{8'hD3, 1'b0, 2'b11, 4'h0, 4'b1111, 1'b0}
`ifndef TD4_HALT_EN
      ,
      '{8'h80, 1'b0, 2'b11, 4'h0, 4'b1111, 1'b0}
`endif
    };

    // Reset state while CLR is low.
    #2;
    chk("rst_ready", {31'd0, READY}, 32'd1);
    chk("rst_load_n", {28'd0, LOAD_N}, 32'hF);
    chk("rst_pc_inc_n", {31'd0, PC_INC_N}, 32'd1);
    chk("rst_sel", {30'd0, SEL}, 32'd3);
    chk("rst_im", {28'd0, IM}, 32'd0);
    chk("rst_c_flag", {31'd0, C_FLAG}, 32'd0);
    chk("rst_halted", {31'd0, HALTED}, 32'd0);
    #10 CLR = 1'b1;
    tick();

    // ADD A,3 with carry out.
    issue(8'h03);
    chk("add_sel", {30'd0, SEL}, 32'd0);
    chk("add_im", {28'd0, IM}, 32'd3);
    chk("add_load_n", {28'd0, LOAD_N}, 32'hE);
    chk("add_pc_inc_n", {31'd0, PC_INC_N}, 32'd0);
    chk("add_ready", {31'd0, READY}, 32'd0);
    retire(1'b1);
    chk("add_c_flag", {31'd0, C_FLAG}, 32'd1);
    chk("add_idle_load_n", {28'd0, LOAD_N}, 32'hF);
    chk("add_idle_pc_inc_n", {31'd0, PC_INC_N}, 32'd1);

    // Decode table: a NOP first sets C_FLAG to the row's precondition.
    foreach (vecs[i]) begin
      issue(8'hA0);
      retire(vecs[i].cpre);
      issue(vecs[i].instr);
      c = 1'($urandom_range(0, 1));
      chk($sformatf("tbl%0d_sel", i), {30'd0, SEL}, {30'd0, vecs[i].sel});
      chk($sformatf("tbl%0d_im", i), {28'd0, IM}, {28'd0, vecs[i].im});
      chk($sformatf("tbl%0d_load_n", i), {28'd0, LOAD_N}, {28'd0, vecs[i].load_n});
      chk($sformatf("tbl%0d_pc_inc_n", i), {31'd0, PC_INC_N}, {31'd0, vecs[i].pc_inc_n});
      retire(c);
      chk($sformatf("tbl%0d_c_flag", i), {31'd0, C_FLAG}, {31'd0, c});
      chk($sformatf("tbl%0d_halted", i), {31'd0, HALTED}, 32'd0);
    end

    // VALID held 6 cycles: EXEC every other cycle.
    wait_ready();
    INSTR = 8'h40;
    VALID = 1'b1;
    exec_count = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (LOAD_N == 4'b1101) exec_count++;
      chk($sformatf("hold%0d_ready", k), {31'd0, READY}, (k % 2 == 1) ? 32'd1 : 32'd0);
    end
    VALID = 1'b0;
    chk("hold_exec_count", exec_count, 32'd3);
    tick();

    // CLR mid-EXEC aborts strobes and clears C_FLAG immediately.
    issue(8'hA0);
    retire(1'b1);
    issue(8'h00);
    CARRY_IN = 1'b1;
    CLR = 1'b0;
    #1;
    chk("abort_load_n", {28'd0, LOAD_N}, 32'hF);
    chk("abort_pc_inc_n", {31'd0, PC_INC_N}, 32'd1);
    chk("abort_ready", {31'd0, READY}, 32'd1);
    chk("abort_c_flag", {31'd0, C_FLAG}, 32'd0);
    // Held in reset across an edge with VALID high; release, then first edge accepts.
    INSTR = 8'h40;
    VALID = 1'b1;
    tick();
    chk("inrst_ready", {31'd0, READY}, 32'd1);
    CLR = 1'b1;
    tick();
    VALID = 1'b0;
    chk("release_load_n", {28'd0, LOAD_N}, 32'hD);
    chk("release_ready", {31'd0, READY}, 32'd0);
    retire(1'b0);

`ifdef TD4_HALT_EN
    issue(8'h80);
    chk("halt_exec_load_n", {28'd0, LOAD_N}, 32'hF);
    chk("halt_exec_pc_inc_n", {31'd0, PC_INC_N}, 32'd1);
    retire(1'b0);
    INSTR = 8'h03;
    VALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("halt%0d_halted", k), {31'd0, HALTED}, 32'd1);
      chk($sformatf("halt%0d_ready", k), {31'd0, READY}, 32'd0);
      chk($sformatf("halt%0d_load_n", k), {28'd0, LOAD_N}, 32'hF);
      tick();
    end
    VALID = 1'b0;
    CLR = 1'b0;
    #1;
    chk("unhalt_halted", {31'd0, HALTED}, 32'd0);
    chk("unhalt_ready", {31'd0, READY}, 32'd1);
    #3 CLR = 1'b1;
    tick();
`else
    issue(8'h80);
    retire(1'b0);
    chk("nohalt_halted", {31'd0, HALTED}, 32'd0);
    chk("nohalt_ready", {31'd0, READY}, 32'd1);
`endif

    // Randomized stream against the reference model.
    cf_model = C_FLAG;
    for (int n = 0; n < 80; n++) begin
      logic [7:0] ins;
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      ins = 8'($urandom);
`ifdef TD4_HALT_EN
      if (ins[7:4] == 4'h8) ins[7:4] = 4'hA;
`endif
      e = model(ins, cf_model);
      issue(ins);
      c = 1'($urandom_range(0, 1));
      chk("rnd_sel", {30'd0, SEL}, {30'd0, e.sel});
      chk("rnd_im", {28'd0, IM}, {28'd0, e.im});
      chk("rnd_load_n", {28'd0, LOAD_N}, {28'd0, e.load_n});
      chk("rnd_pc_inc_n", {31'd0, PC_INC_N}, {31'd0, e.pc_inc_n});
      chk("rnd_ready", {31'd0, READY}, 32'd0);
      retire(c);
      cf_model = c;
      chk("rnd_c_flag", {31'd0, C_FLAG}, {31'd0, cf_model});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_sequencer.md
LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 SHALL have parameter: bitWidth, 4, immediate/data width; instruction width is 4+bitWidth.
REQ-002 SHALL have port: CLK  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: CLR  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: INSTR  input  4+bitWidth  instruction; [bitWidth+3:bitWidth] opcode, [bitWidth-1:0] immediate.
REQ-005 SHALL have port: VALID  input  1  INSTR valid (source to sequencer).
REQ-006 SHALL have port: READY  output  1  sequencer accepts INSTR this cycle.
REQ-007 SHALL have port: CARRY_IN  input  1  ALU carry of the instruction currently executing.
REQ-008 SHALL have port: SEL  output  2  ALU source: 00 A, 01 B, 10 IN port, 11 zero.
REQ-009 SHALL have port: IM  output  bitWidth  immediate to ALU.
REQ-010 SHALL have port: LOAD_N  output  4  active-low register chip selects [0]A [1]B [2]OUT [3]PC.
REQ-011 SHALL have port: PC_INC_N  output  1  active-low PC increment strobe.
REQ-012 SHALL have port: C_FLAG  output  1  latched carry flag.
REQ-013 SHALL have port: HALTED  output  1  sequencer halted (see Configuration).

Function
REQ-014 SHALL implement states IDLE, EXEC, HALT.
REQ-015 IDLE: READY=1; VALID=1 at edge -> latch INSTR, go EXEC; else stay.
REQ-016 EXEC: exactly one cycle, READY=0, strobes driven from latched instruction; next state IDLE (or HALT per REQ-028).
REQ-017 Outside EXEC, LOAD_N SHALL be 4'b1111 and PC_INC_N 1; SEL=11, IM=0.
REQ-018 Decode in EXEC (opcode: SEL, IM, LOAD_N low bit): 0000 ADD A,Im: 00,Im,A; 0101 ADD B,Im: 01,Im,B; 0011 MOV A,Im: 11,Im,A; 0111 MOV B,Im: 11,Im,B; 0001 MOV A,B: 01,0,A; 0100 MOV B,A: 00,0,B; 0010 IN A: 10,0,A; 0110 IN B: 10,0,B; 1011 OUT Im: 11,Im,OUT; 1001 OUT B: 01,0,OUT; 1111 JMP Im: 11,Im,PC; 1110 JNC Im: 11,Im,PC only if C_FLAG=0.
REQ-019 PC_INC_N SHALL be 0 in EXEC whenever LOAD_N[3]=1 (never both asserted).
REQ-020 Undefined opcodes SHALL execute as NOP: LOAD_N=1111, PC_INC_N=0.
REQ-021 C_FLAG SHALL load CARRY_IN at the end of every EXEC cycle (all opcodes incl. NOP); JNC SHALL test the value held before that edge.
REQ-022 Throughput: one instruction per two cycles; VALID held through an EXEC cycle is not consumed until the following IDLE.

Reset
REQ-023 CLR=0 SHALL immediately force state IDLE, latched instruction 0, C_FLAG=0, HALTED=0, LOAD_N=1111, PC_INC_N=1, SEL=11, IM=0, independent of CLK.
REQ-024 CLR asserted during EXEC SHALL abort it: no strobe remains asserted, C_FLAG not updated.
REQ-025 First acceptance after CLR release SHALL occur at the first rising edge with CLR=1 and VALID=1.

Configuration
REQ-026 Macro TD4_HALT_EN SHALL control halt support.
REQ-027 Without TD4_HALT_EN: opcode 1000 is NOP; HALTED tied 0; HALT state absent.
REQ-028 With TD4_HALT_EN: opcode 1000 executes one EXEC cycle with no strobes (PC_INC_N=1), then enters HALT; HALT holds READY=0, HALTED=1 until CLR.

Structure
REQ-029 Shared package td4_pkg SHALL hold opcode constants, SEL encodings, LOAD_N bit indices and state encoding.
REQ-030 Combinational decode SHALL be sub-module opcode_decoder (opcode, C_FLAG -> SEL, IM-enable, LOAD_N, PC_INC_N); load_sequencer owns FSM, instruction latch and carry flag.

Verification
REQ-031 Reset: CLR=0 mid-EXEC of 0000 -> LOAD_N=1111, READY=1, C_FLAG=0 within same timestep.
REQ-032 ADD A,3 (INSTR=8'h03), CARRY_IN=1 -> EXEC: SEL=00, IM=3, LOAD_N=1110, PC_INC_N=0; C_FLAG=1 after edge.
REQ-033 JNC 5 (8'hE5) after C_FLAG=1 -> LOAD_N=1111, PC_INC_N=0; after C_FLAG=0 -> LOAD_N=0111, IM=5, PC_INC_N=1.
REQ-034 VALID held high for 6 cycles with MOV B,A (8'h40) -> exactly 3 EXEC cycles, LOAD_N=1101 each, READY toggling 1/0.
REQ-035 Undefined 8'hA0 -> NOP strobes; with TD4_HALT_EN, 8'h80 -> HALTED=1, READY=0 until CLR; without, 8'h80 -> NOP.
